uart_bus_ctrl: RTL and testbench

- Memory-mapped controller sitting between the single-cycle CPU data bus and the UART receiver/transmitter pair.
- Buffers received bytes in a small RX FIFO fed by the receiver's one-cycle RX_STATUS pulse.
- Double-buffers CPU transmit writes and sequences the transmitter with a launch/busy/done handshake.
- Exposes status/control registers and a level interrupt to the CPU.

---
 rtl/uart_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: RX byte FIFO, double-buffered TX sequencer,
// control/status register and a level interrupt for the CPU data bus.
module uart_bus_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD   = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD   = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON   = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] rdata,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  input  logic        tx_status,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        irq
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} tx_state_e;

  tx_state_e       state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overrun_q, tx_pend_q, tx_done_q, rx_ie_q, tx_ie_q;
  logic [7:0]      tx_hold_q;

  logic        full, nonempty, pop, push, ovf_set, con_wr, txd_wr, flush, txd_accept;
  logic [2:0]  cnt_disp;
  logic [31:0] con_status;
  logic        unused_wdata;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign nonempty = (count_q != '0);
  assign pop      = memread && (addr == ADDR_RXD) && nonempty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push     = rx_status && (!full || pop);
  assign ovf_set  = rx_status && full && !pop;
  assign con_wr   = memwrite && (addr == ADDR_CON);
  assign txd_wr   = memwrite && (addr == ADDR_TXD);
  assign flush    = con_wr && wdata[3];
  // tx_pend clears on the edge leaving LAUNCH, so a write landing then is taken.
  assign txd_accept = txd_wr && (!tx_pend_q || (state_q == StLaunch));
  assign unused_wdata = ^{wdata[31:8], wdata[4]};

  always_comb begin
    cnt_disp = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);
  end

  assign con_status = {21'b0, tx_ie_q, rx_ie_q, cnt_disp, tx_done_q, (state_q != StIdle),
                       tx_pend_q, overrun_q, full, nonempty};

  always_comb begin
    rdata = '0;
    if (memread) begin
      if (addr == ADDR_RXD) begin
        rdata = pop ? {24'b0, mem_q[rd_ptr_q]} : '0;
      end else if (addr == ADDR_CON) begin
        rdata = con_status;
      end
    end
  end

  assign irq = (rx_ie_q && nonempty) || (tx_ie_q && tx_done_q) || overrun_q;

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
      if (ovf_set)                overrun_q <= 1'b1;
      else if (con_wr && wdata[2]) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      tx_hold_q <= '0;
      tx_pend_q <= 1'b0;
      tx_done_q <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      if (txd_accept) begin
        tx_hold_q <= wdata[7:0];
        tx_pend_q <= 1'b1;
      end else if (state_q == StLaunch) begin
        tx_pend_q <= 1'b0;
      end
      if (con_wr) begin
        rx_ie_q <= wdata[0];
        tx_ie_q <= wdata[1];
        if (wdata[5]) tx_done_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (tx_pend_q && tx_status) begin
            state_q <= StLaunch;
            tx_en   <= 1'b1;
            tx_data <= tx_hold_q;
          end
        end
        StLaunch: state_q <= StBusy;
        StBusy:   if (!tx_status) state_q <= StDone;
        StDone: begin
          if (tx_status) begin
            tx_done_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl: bus tasks, a transmitter model that holds
// tx_status low for 10 cycles per launch, and hand-computed expected values.
module tb_uart_bus_ctrl;

  localparam logic [31:0] ATxd = 32'h4000_0018;
  localparam logic [31:0] ARxd = 32'h4000_001C;
  localparam logic [31:0] ACon = 32'h4000_0020;

  logic        clk, reset;
  logic [31:0] addr, wdata, rdata;
  logic        memwrite, memread, rx_status, tx_status, tx_en, irq;
  logic [7:0]  rx_data, tx_data;

  int vectors = 0;
  int miscompares = 0;
  int n_tx = 0;
  logic [7:0] tx_log [8];
  logic [31:0] rd;
  int saved_tx;

  uart_bus_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .memwrite(memwrite),
    .memread(memread), .rdata(rdata), .rx_status(rx_status), .rx_data(rx_data),
    .tx_status(tx_status), .tx_en(tx_en), .tx_data(tx_data), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; memread = 1'b1;
    #2 d = rdata;
    step();
    memread = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; memwrite = 1'b1;
    step();
    memwrite = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_status = 1'b1; rx_data = b;
    step();
    rx_status = 1'b0; rx_data = '0;
  endtask

  // Transmitter model: goes busy right after a launch and idles 10 cycles later.
  initial begin
    tx_status = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        if (n_tx < 8) tx_log[n_tx] = tx_data;
        n_tx++;
        tx_status = 1'b0;
        repeat (10) @(negedge clk);
        tx_status = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; memwrite = 1'b0; memread = 1'b0;
    rx_status = 1'b0; rx_data = '0;
    repeat (3) step();
    check_eq("rst_tx_en", {31'b0, tx_en}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(ACon, rd);
    check_eq("rst_con", rd, 32'h0);
    reset = 1'b1;
    step();

    rx_push(8'hA5);
    bus_read(ARxd, rd);
    check_eq("rxd_a5", rd, 32'h0000_00A5);
    bus_read(ACon, rd);
    check_eq("con_after_pop", rd, 32'h0);

    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    bus_read(ACon, rd);
    check_eq("con_full_ovr", rd, 32'h0000_0107);
    for (int i = 1; i <= 4; i++) begin
      bus_read(ARxd, rd);
      check_eq("rxd_fill", rd, 32'(i));
    end
    bus_read(ARxd, rd);
    check_eq("rxd_empty", rd, 32'h0);
    bus_read(ACon, rd);
    check_eq("con_ovr_only", rd, 32'h0000_0004);
    bus_write(ACon, 32'h4);
    bus_read(ACon, rd);
    check_eq("con_ovr_clr", rd, 32'h0);

    for (int i = 0; i < 4; i++) rx_push(8'h11 + 8'(i));
    bus_read(ACon, rd);
    check_eq("con_full", rd, 32'h0000_0103);
    rx_status = 1'b1; rx_data = 8'h15; addr = ARxd; memread = 1'b1;
    #2 rd = rdata;
    step();
    rx_status = 1'b0; memread = 1'b0; addr = '0;
    check_eq("simul_pop", rd, 32'h11);
    bus_read(ACon, rd);
    check_eq("simul_con", rd, 32'h0000_0103);
    for (int i = 0; i < 4; i++) begin
      bus_read(ARxd, rd);
      check_eq("simul_drain", rd, 32'h12 + 32'(i));
    end

    rx_push(8'h21); rx_push(8'h22);
    bus_read(ACon, rd);
    check_eq("con_cnt2", rd, 32'h0000_0081);
    addr = ACon; wdata = 32'h8; memwrite = 1'b1; rx_status = 1'b1; rx_data = 8'h23;
    step();
    memwrite = 1'b0; rx_status = 1'b0; addr = '0; wdata = '0;
    bus_read(ACon, rd);
    check_eq("con_flush", rd, 32'h0);
    bus_read(ARxd, rd);
    check_eq("rxd_flush", rd, 32'h0);

    bus_write(ATxd, 32'h5A);
    repeat (2) step();
    bus_write(ATxd, 32'h3C);
    bus_write(ATxd, 32'h77);
    bus_read(ACon, rd);
    check_eq("con_tx_pend", rd, 32'h0000_0018);
    repeat (60) step();
    check_eq("tx_count", 32'(n_tx), 32'd2);
    check_eq("tx_byte0", {24'b0, tx_log[0]}, 32'h5A);
    check_eq("tx_byte1", {24'b0, tx_log[1]}, 32'h3C);
    bus_read(ACon, rd);
    check_eq("con_tx_done", rd, 32'h0000_0020);

    bus_write(ACon, 32'h23);
    check_eq("irq_clr0", {31'b0, irq}, 32'h0);
    rx_push(8'h66);
    check_eq("irq_rx", {31'b0, irq}, 32'h1);
    bus_read(ARxd, rd);
    check_eq("irq_pop_data", rd, 32'h66);
    check_eq("irq_pop", {31'b0, irq}, 32'h0);
    bus_write(ATxd, 32'h99);
    repeat (30) step();
    check_eq("irq_tx", {31'b0, irq}, 32'h1);
    check_eq("tx_byte2", {24'b0, tx_log[2]}, 32'h99);
    bus_write(ACon, 32'h23);
    check_eq("irq_done_clr", {31'b0, irq}, 32'h0);

    rx_push(8'h31); rx_push(8'h32);
    bus_write(ATxd, 32'h42);
    repeat (2) step();
    saved_tx = n_tx;
    bus_read(ACon, rd);
    check_eq("pre_rst_con", rd, 32'h0000_0691);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_tx_en", {31'b0, tx_en}, 32'h0);
    check_eq("mid_rst_tx_data", {24'b0, tx_data}, 32'h0);
    check_eq("mid_rst_irq", {31'b0, irq}, 32'h0);
    bus_read(ACon, rd);
    check_eq("mid_rst_con", rd, 32'h0);
    reset = 1'b1;
    repeat (30) step();
    check_eq("post_rst_no_tx", 32'(n_tx), 32'(saved_tx));
    bus_read(ACon, rd);
    check_eq("post_rst_con", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
